// File: rtl/bitrev_pkg.sv
// Shared types for the bit-reversal core.
//   bank_e     : ping-pong bank identifier
//   other_bank : returns the opposite bank
package bitrev_pkg;

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_e;

  function automatic bank_e other_bank(input bank_e b);
    return (b == BANK_0) ? BANK_1 : BANK_0;
  endfunction

endpackage

// File: rtl/bitrev_bank.sv
// Single storage bank: DEPTH x DW words, synchronous write, asynchronous read.
// Contents are deliberately not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module bitrev_bank #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 1 << AW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/bitrev.sv
// Streaming bit-reversal permutation for radix-2 FFT pipelines.
// Frames of N = 2^K words enter in natural order and leave in bit-reversed
// order; two banks ping-pong so one frame is written while the other is read.
//   clk_i   : clock
//   rst_ni  : asynchronous reset, active low
//   valid_i : input word valid
//   data_i  : input word (natural order)
//   ready_o : core can accept an input word
//   valid_o : output word valid
//   data_o  : output word (bit-reversed order), zero when not valid
//   ready_i : downstream accepts the output word
module bitrev
  import bitrev_pkg::*;
#(
  parameter int unsigned K  = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i
);

  localparam int unsigned N = 1 << K;

  function automatic logic [K-1:0] rev_k(input logic [K-1:0] x);
    logic [K-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < K; i++) r[i] = x[K-1-i];
    return r;
  endfunction

  logic [K-1:0]  wr_cnt, rd_cnt;
  bank_e         wb, rb;
  logic [1:0]    full, full_nxt;
  logic          wr_fire, rd_fire;
  logic          wr_last, rd_last;
  logic [K-1:0]  raddr;
  logic [DW-1:0] rdata0, rdata1;

  assign ready_o = !full[wb];
  assign valid_o = full[rb];
  assign wr_fire = valid_i & ready_o;
  assign rd_fire = valid_o & ready_i;
  assign wr_last = wr_fire && (wr_cnt == '1);
  assign rd_last = rd_fire && (rd_cnt == '1);
  assign raddr   = rev_k(rd_cnt);

  // A writer only targets an empty bank and a reader only a full one, so
  // completing both in one cycle always touches different flag bits.
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wb] = 1'b1;
    if (rd_last) full_nxt[rb] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      wb     <= BANK_0;
      rb     <= BANK_0;
      full   <= '0;
    end else begin
      if (wr_fire) wr_cnt <= wr_cnt + 1'b1;
      if (rd_fire) rd_cnt <= rd_cnt + 1'b1;
      if (wr_last) wb <= other_bank(wb);
      if (rd_last) rb <= other_bank(rb);
      full <= full_nxt;
    end
  end

  bitrev_bank #(
    .AW   (K),
    .DW   (DW),
    .DEPTH(N)
  ) u_bank0 (
    .clk_i  (clk_i),
    .we_i   (wr_fire && (wb == BANK_0)),
    .waddr_i(wr_cnt),
    .wdata_i(data_i),
    .raddr_i(raddr),
    .rdata_o(rdata0)
  );

  bitrev_bank #(
    .AW   (K),
    .DW   (DW),
    .DEPTH(N)
  ) u_bank1 (
    .clk_i  (clk_i),
    .we_i   (wr_fire && (wb == BANK_1)),
    .waddr_i(wr_cnt),
    .wdata_i(data_i),
    .raddr_i(raddr),
    .rdata_o(rdata1)
  );

  assign data_o = !valid_o ? '0 : (rb == BANK_0) ? rdata0 : rdata1;

endmodule

// File: tb/tb_bitrev.sv
module tb_bitrev;

  localparam int unsigned K  = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 1 << K;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          valid_i, ready_i, ready_o, valid_o;
  logic [DW-1:0] data_i, data_o;

  logic          s_valid_i, s_ready_i, s_ready_o, s_valid_o;
  logic [7:0]    s_data_i, s_data_o;

  always #5 clk_i = ~clk_i;

  bitrev #(.K(K), .DW(DW)) u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(valid_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o (data_o),
    .ready_i(ready_i)
  );

  bitrev #(.K(3), .DW(8)) u_small (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(s_valid_i),
    .data_i (s_data_i),
    .ready_o(s_ready_o),
    .valid_o(s_valid_o),
    .data_o (s_data_o),
    .ready_i(s_ready_i)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect a frame in natural order, then publish it as
  // the list of words in the order they must come out.
  function automatic int unsigned rev_ref(input int unsigned j, input int unsigned k);
    int unsigned r = 0;
    int unsigned v = j;
    repeat (k) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_frame[$];
  logic [DW-1:0] pend_frame[$];
  bit            pending;
  bit            mon_en;
  bit            hold_pending;
  logic [DW-1:0] hold_data;
  int unsigned   accepted;
  int unsigned   wr_prob, rd_prob;
  bit            seq_data;
  logic [DW-1:0] next_val;

  // Monitor / scoreboard
  always @(negedge clk_i) begin
    if (rst_ni && mon_en) begin
      int unsigned frames;
      frames = (exp_q.size() + N - 1) / N;
      chk("valid_o", valid_o, exp_q.size() > 0);
      chk("ready_o", ready_o, frames < 2);
      if (!valid_o) chk("data_o_idle", data_o, 0);
      if (hold_pending) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_data", data_o, hold_data);
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else chk("data_o", data_o, exp_q.pop_front());
      end
      hold_pending = valid_o && !ready_i;
      hold_data    = data_o;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    if (pending) begin
      foreach (pend_frame[i]) exp_q.push_back(pend_frame[i]);
      pend_frame.delete();
      pending = 0;
    end
    valid_i = ($urandom_range(99) < wr_prob);
    data_i  = seq_data ? next_val : DW'($urandom);
    ready_i = ($urandom_range(99) < rd_prob);
    @(negedge clk_i);
    if (valid_i && ready_o) begin
      cur_frame.push_back(data_i);
      accepted++;
      next_val = next_val + 1;
      if (cur_frame.size() == N) begin
        for (int unsigned j = 0; j < N; j++) pend_frame.push_back(cur_frame[rev_ref(j, K)]);
        cur_frame.delete();
        pending = 1;
      end
    end
  endtask

  task automatic feed(input int unsigned n, input int unsigned wp, input int unsigned rp);
    int unsigned target = accepted + n;
    int unsigned budget = 0;
    wr_prob = wp;
    rd_prob = rp;
    while (accepted < target && budget < 20000) begin
      step();
      budget++;
    end
    if (accepted < target) chk("feed_timeout", accepted, target);
    wr_prob = 0;
  endtask

  task automatic idle(input int unsigned n, input int unsigned rp);
    wr_prob = 0;
    rd_prob = rp;
    repeat (n) step();
  endtask

  task automatic drain(input int unsigned rp);
    int unsigned budget = 0;
    wr_prob = 0;
    rd_prob = rp;
    while ((exp_q.size() != 0 || pending) && budget < 20000) begin
      step();
      budget++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("rst_ready_o", ready_o, 1);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_data_o", data_o, 0);
    exp_q.delete();
    cur_frame.delete();
    pend_frame.delete();
    pending      = 0;
    hold_pending = 0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [7:0] s_exp [8];
    int unsigned s_got, s_in, budget;
    s_exp = '{8'd0, 8'd4, 8'd2, 8'd6, 8'd1, 8'd5, 8'd3, 8'd7};
    rst_ni = 1'b0; valid_i = 0; ready_i = 0; data_i = '0;
    s_valid_i = 0; s_ready_i = 0; s_data_i = '0;
    pending = 0; mon_en = 0; hold_pending = 0; accepted = 0;
    wr_prob = 0; rd_prob = 0; seq_data = 1; next_val = '0;
    #22;
    chk("init_ready_o", ready_o, 1);
    chk("init_valid_o", valid_o, 0);
    chk("init_data_o", data_o, 0);
    chk("init_s_ready_o", s_ready_o, 1);
    chk("init_s_valid_o", s_valid_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    mon_en = 1;

    // Idle after reset
    idle(6, 100);
    // One frame, natural counting data, full throughput
    next_val = 0;
    feed(N, 100, 100);
    drain(100);
    idle(3, 100);
    // Two frames with reader stalled: core must fill and block
    next_val = 0;
    feed(2 * N, 100, 0);
    wr_prob = 100;
    rd_prob = 0;
    repeat (5) step();
    chk("both_full_accepted", accepted, 3 * N);
    wr_prob = 0;
    drain(100);
    // Random throttling over three frames, random data
    seq_data = 0;
    feed(3 * N, 70, 60);
    drain(50);
    // Reset during a partial write
    seq_data = 1;
    next_val = 32'h1000;
    feed(500, 100, 100);
    do_reset();
    idle(2, 100);
    feed(N, 100, 100);
    drain(100);
    // Reset in the middle of reading a frame
    feed(N, 100, 0);
    idle(2, 0);
    idle(300, 100);
    chk("mid_read_busy", valid_o, 1);
    do_reset();
    idle(2, 100);
    seq_data = 0;
    feed(N, 90, 80);
    drain(100);
    mon_en = 0;

    // Small instance K=3, DW=8
    @(posedge clk_i); #1;
    s_in = 0; budget = 0;
    while (s_in < 8 && budget < 100) begin
      s_valid_i = 1'b1;
      s_data_i  = 8'(s_in);
      @(negedge clk_i);
      if (s_ready_o) s_in++;
      @(posedge clk_i); #1;
      budget++;
    end
    s_valid_i = 1'b0;
    s_ready_i = 1'b1;
    s_got = 0; budget = 0;
    while (s_got < 8 && budget < 100) begin
      @(negedge clk_i);
      if (s_valid_o) begin
        chk("small_data_o", s_data_o, s_exp[s_got]);
        s_got++;
      end
      budget++;
    end
    chk("small_count", s_got, 8);
    @(negedge clk_i);
    chk("small_valid_end", s_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
